// File: rtl/lcd_text_engine_pkg.sv
// Shared constants and state encodings for the HD44780-style text engine.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_SET  = 8'h38;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_ENTRY     = 8'h06;
  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

  // DDRAM start address of each display row, indexed by row number
  localparam logic [3:0][7:0] ROW_BASE = {8'h54, 8'h14, 8'h40, 8'h00};

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_SET_ADDR, ST_PUT_CHAR, ST_NEXT_ROW
  } state_t;

  typedef enum logic [1:0] {
    W_IDLE, W_SETUP, W_EN, W_SETTLE
  } wstate_t;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_CLEAR;
      default: return CMD_ENTRY;
    endcase
  endfunction

endpackage

// File: rtl/lcd_text_engine_if.sv
// Host character-write port of the text engine.
interface lcd_text_engine_if #(parameter int AW = 3);
  logic          iWR;
  logic [AW-1:0] iADDR;
  logic [7:0]    iCHAR;

  modport master (output iWR, iADDR, iCHAR);
  modport slave  (input  iWR, iADDR, iCHAR);
endinterface

// File: rtl/lcd_text_engine_byte_writer.sv
// One LCD bus transfer: setup cycle, EN strobe, then settle; done pulses once after settle.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int EN_CYCLES  = 16,
  parameter int DLY_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       rs,
  input  logic       long_settle,
  output logic       done,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_en
);

  localparam int CW = $clog2(4*DLY_CYCLES + EN_CYCLES + 1);

  wstate_t       ws;
  logic [CW-1:0] cnt;
  logic          long_q;
  logic [CW-1:0] settle_len;

  assign settle_len = long_q ? CW'(4*DLY_CYCLES) : CW'(DLY_CYCLES);

  // lcd_data/lcd_rs only change on an accepted start, so they stay put through EN and settle
  always_ff @(posedge clk) begin
    if (rst) begin
      ws       <= W_IDLE;
      cnt      <= '0;
      long_q   <= 1'b0;
      done     <= 1'b0;
      lcd_data <= 8'h00;
      lcd_rs   <= 1'b0;
      lcd_en   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (ws)
        W_IDLE: if (start) begin
          lcd_data <= data;
          lcd_rs   <= rs;
          long_q   <= long_settle;
          ws       <= W_SETUP;
        end
        W_SETUP: begin
          lcd_en <= 1'b1;
          cnt    <= CW'(1);
          ws     <= W_EN;
        end
        W_EN: if (cnt == CW'(EN_CYCLES)) begin
          lcd_en <= 1'b0;
          cnt    <= CW'(1);
          ws     <= W_SETTLE;
        end else begin
          cnt <= cnt + CW'(1);
        end
        W_SETTLE: if (cnt == settle_len) begin
          done <= 1'b1;
          cnt  <= '0;
          ws   <= W_IDLE;
        end else begin
          cnt <= cnt + CW'(1);
        end
        default: ws <= W_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lcd_text_engine.sv
// Character LCD text engine: shadow buffer plus init/refresh sequencer.
// Optional macro LCD_AUTO_REFRESH_EN adds a periodic refresh after 2^20 idle clocks.
module lcd_text_engine
  import lcd_pkg::*;
#(
  parameter int COLS       = 16,
  parameter int ROWS       = 2,
  parameter int EN_CYCLES  = 16,
  parameter int DLY_CYCLES = 50000
) (
  input  logic               iCLK,
  input  logic               iRST,
  lcd_text_engine_if.slave   host,
  output logic               oINIT_DONE,
  output logic               oBUSY,
  output logic [7:0]         LCD_DATA,
  output logic               LCD_RS,
  output logic               LCD_RW,
  output logic               LCD_EN
);

  localparam int NPOS = ROWS*COLS;
  localparam int PW   = $clog2(NPOS);
  localparam int CCW  = $clog2(COLS);
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [NPOS-1:0][7:0] shadow;
  state_t               state;
  logic                 dirty, pend, start, rs_q, long_q, done;
  logic [7:0]           byte_q;
  logic [1:0]           init_idx;
  logic [RW-1:0]        row;
  logic [CCW-1:0]       col;
  logic                 wr_ok, refresh_go;
  logic [PW-1:0]        wr_pos, rd_pos;

  assign wr_ok  = host.iWR && (int'(host.iADDR) < NPOS);
  assign wr_pos = host.iADDR[PW-1:0];
  assign rd_pos = PW'(int'(row) * COLS + int'(col));
  assign LCD_RW = 1'b0;

`ifdef LCD_AUTO_REFRESH_EN
  logic [19:0] idle_cnt;
  assign refresh_go = dirty || (idle_cnt == 20'hFFFFF);
  always_ff @(posedge iCLK) begin
    if (iRST || state != ST_IDLE || refresh_go) idle_cnt <= '0;
    else                                      idle_cnt <= idle_cnt + 20'd1;
  end
`else
  assign refresh_go = dirty;
`endif

  // Each byte state issues one start, then waits for done with pend set.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state      <= ST_INIT;
      shadow     <= {NPOS{8'h20}};
      dirty      <= 1'b0;
      pend       <= 1'b0;
      start      <= 1'b0;
      byte_q     <= 8'h00;
      rs_q       <= 1'b0;
      long_q     <= 1'b0;
      init_idx   <= 2'd0;
      row        <= '0;
      col        <= '0;
      oINIT_DONE <= 1'b0;
      oBUSY      <= 1'b1;
    end else begin
      start <= 1'b0;
      if (wr_ok) shadow[wr_pos] <= host.iCHAR;
      case (state)
        ST_INIT: if (!pend) begin
          start  <= 1'b1;
          pend   <= 1'b1;
          byte_q <= init_cmd(init_idx);
          rs_q   <= 1'b0;
          long_q <= (init_cmd(init_idx) == CMD_CLEAR);
        end else if (done) begin
          pend <= 1'b0;
          if (init_idx == 2'd3) begin
            state      <= ST_IDLE;
            oINIT_DONE <= 1'b1;
            oBUSY      <= 1'b0;
            dirty      <= 1'b1;
          end else begin
            init_idx <= init_idx + 2'd1;
          end
        end
        ST_IDLE: if (refresh_go) begin
          state <= ST_SET_ADDR;
          row   <= '0;
          oBUSY <= 1'b1;
          dirty <= 1'b0;
        end
        ST_SET_ADDR: if (!pend) begin
          start  <= 1'b1;
          pend   <= 1'b1;
          byte_q <= CMD_SET_DDRAM | ROW_BASE[2'(row)];
          rs_q   <= 1'b0;
          long_q <= 1'b0;
        end else if (done) begin
          pend  <= 1'b0;
          col   <= '0;
          state <= ST_PUT_CHAR;
        end
        ST_PUT_CHAR: if (!pend) begin
          start  <= 1'b1;
          pend   <= 1'b1;
          byte_q <= shadow[rd_pos];
          rs_q   <= 1'b1;
          long_q <= 1'b0;
        end else if (done) begin
          pend <= 1'b0;
          if (col == CCW'(COLS-1)) state <= ST_NEXT_ROW;
          else                     col   <= col + CCW'(1);
        end
        ST_NEXT_ROW: if (row == RW'(ROWS-1)) begin
          state <= ST_IDLE;
          oBUSY <= 1'b0;
        end else begin
          row   <= row + RW'(1);
          state <= ST_SET_ADDR;
        end
        default: state <= ST_INIT;
      endcase
      // a write landing on the refresh-start cycle must still cause another pass
      if (wr_ok) dirty <= 1'b1;
    end
  end

  lcd_byte_writer #(.EN_CYCLES(EN_CYCLES), .DLY_CYCLES(DLY_CYCLES)) u_writer (
    .clk        (iCLK),
    .rst        (iRST),
    .start      (start),
    .data       (byte_q),
    .rs         (rs_q),
    .long_settle(long_q),
    .done       (done),
    .lcd_data   (LCD_DATA),
    .lcd_rs     (LCD_RS),
    .lcd_en     (LCD_EN)
  );

endmodule

// File: tb/tb_lcd_text_engine.sv
// Bench for lcd_text_engine: expected LCD byte stream model plus bus timing monitor.
module tb_lcd_text_engine;

  localparam int COLS = 4, ROWS = 2, ENC = 2, DLY = 4;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic       oINIT_DONE, oBUSY, LCD_RS, LCD_RW, LCD_EN;
  logic [7:0] LCD_DATA;

  lcd_text_engine_if #(.AW(4)) host();

  lcd_text_engine #(.COLS(COLS), .ROWS(ROWS), .EN_CYCLES(ENC), .DLY_CYCLES(DLY)) dut (
    .iCLK(iCLK), .iRST(iRST), .host(host),
    .oINIT_DONE(oINIT_DONE), .oBUSY(oBUSY),
    .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN)
  );

  always #5 iCLK = ~iCLK;

  int n_checks = 0, n_fail = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // model: display content and the byte stream the LCD must receive
  logic [7:0] mdl [COLS*ROWS];
  logic [8:0] exp_q [$];
  logic [8:0] seen [$];

  task automatic model_clear();
    for (int i = 0; i < COLS*ROWS; i++) mdl[i] = 8'h20;
    exp_q.delete();
  endtask

  task automatic push_init();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h006);
  endtask

  task automatic push_refresh();
    logic [7:0] base [2];
    base[0] = 8'h00;
    base[1] = 8'h40;
    for (int r = 0; r < ROWS; r++) begin
      exp_q.push_back({1'b0, 8'h80 | base[r]});
      for (int c = 0; c < COLS; c++) exp_q.push_back({1'b1, mdl[r*COLS + c]});
    end
  endtask

  // monitor: byte order, EN width, setup/hold stability, settle gap, busy, init_done
  int         cyc = 0, en_w = 0, fall_cyc = 0, need = DLY + 1, en_rises = 0;
  bit         en_prev = 0, id_prev = 0, have_fall = 0;
  logic [8:0] rise_byte = '0, prev_byte = '0, e;

  always @(negedge iCLK) begin
    cyc++;
    if (iRST) begin
      en_prev = 0; id_prev = 0; have_fall = 0; en_w = 0;
    end else begin
      check(LCD_RW == 1'b0, "lcd_rw", LCD_RW, 0);
      if (LCD_EN && !en_prev) begin
        en_rises++;
        en_w = 1;
        rise_byte = {LCD_RS, LCD_DATA};
        seen.push_back(rise_byte);
        check(rise_byte == prev_byte, "setup_stable", rise_byte, prev_byte);
        if (have_fall) check(cyc - fall_cyc >= need, "settle_gap", cyc - fall_cyc, need);
        if (exp_q.size() == 0) check(0, "unexpected_byte", rise_byte, 0);
        else begin
          e = exp_q.pop_front();
          check(rise_byte == e, "lcd_byte", rise_byte, e);
        end
        check(oBUSY == 1'b1, "busy_in_xfer", oBUSY, 1);
      end else begin
        if (LCD_EN) en_w++;
        if (!LCD_EN && en_prev) begin
          check(en_w == ENC, "en_width", en_w, ENC);
          fall_cyc = cyc;
          have_fall = 1;
          need = (rise_byte == 9'h001) ? 4*DLY + 1 : DLY + 1;
        end
        if (LCD_EN || (have_fall && cyc - fall_cyc < need - 1)) begin
          check({LCD_RS, LCD_DATA} == rise_byte, "hold_stable", {LCD_RS, LCD_DATA}, rise_byte);
          check(oBUSY == 1'b1, "busy_in_xfer", oBUSY, 1);
        end
      end
      if (oINIT_DONE && !id_prev) begin
        check(rise_byte == 9'h006, "init_done_last_cmd", rise_byte, 9'h006);
        check(cyc - fall_cyc >= DLY && cyc - fall_cyc <= DLY + 3, "init_done_after_settle",
              cyc - fall_cyc, DLY + 1);
      end
      if (!oINIT_DONE && id_prev) check(0, "init_done_dropped", 0, 1);
      en_prev = LCD_EN;
      id_prev = oINIT_DONE;
    end
    prev_byte = {LCD_RS, LCD_DATA};
  end

  task automatic write(input int addr, input logic [7:0] ch);
    @(negedge iCLK);
    host.iWR = 1'b1;
    host.iADDR = 4'(addr);
    host.iCHAR = ch;
    if (addr < COLS*ROWS) mdl[addr] = ch;
    @(negedge iCLK);
    host.iWR = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && oBUSY == 1'b0 && !LCD_EN) && n < 3000) begin
      @(negedge iCLK);
      n++;
    end
    check(n < 3000, name, n, 3000);
    repeat (30) @(negedge iCLK);
  endtask

  function automatic logic [8:0] seen_at(input int i);
    return (i < seen.size()) ? seen[i] : 9'h1FF;
  endfunction

  int base, n, r0;

  initial begin
    host.iWR = 1'b0;
    host.iADDR = '0;
    host.iCHAR = '0;
    model_clear();
    repeat (3) @(negedge iCLK);
    check(LCD_EN == 0, "rst_en", LCD_EN, 0);
    check(LCD_RS == 0, "rst_rs", LCD_RS, 0);
    check(LCD_DATA == 0, "rst_data", LCD_DATA, 0);
    check(oINIT_DONE == 0, "rst_init_done", oINIT_DONE, 0);
    check(oBUSY == 1, "rst_busy", oBUSY, 1);

    // power-up: init commands then one full refresh of spaces
    push_init();
    push_refresh();
    #1 iRST = 1'b0;
    wait_idle("init_timeout");
    check(seen_at(0) == 9'h038, "init_b0", seen_at(0), 9'h038);
    check(seen_at(2) == 9'h001, "init_b2", seen_at(2), 9'h001);
    check(seen_at(3) == 9'h006, "init_b3", seen_at(3), 9'h006);
    check(seen_at(4) == 9'h080, "row0_addr", seen_at(4), 9'h080);
    check(seen_at(5) == 9'h120, "row0_space", seen_at(5), 9'h120);
    check(seen_at(9) == 9'h0C0, "row1_addr", seen_at(9), 9'h0C0);
    check(oINIT_DONE == 1, "init_done_hi", oINIT_DONE, 1);
    check(oBUSY == 0, "idle_busy", oBUSY, 0);

    // single write -> one refresh carrying the new character
    base = seen.size();
    write(5, 8'h41);
    push_refresh();
    n = 0;
    while (!oBUSY && n < 5) begin @(negedge iCLK); n++; end
    check(oBUSY == 1, "busy_after_write", oBUSY, 1);
    wait_idle("refresh1_timeout");
    check(seen_at(base + 7) == 9'h141, "row1_col1", seen_at(base + 7), 9'h141);
    check(seen_at(base + 6) == 9'h120, "row1_col0", seen_at(base + 6), 9'h120);
    check(seen.size() == base + 10, "refresh1_len", seen.size() - base, 10);

    // write to an already-sent position mid-refresh -> exactly one more refresh
    base = seen.size();
    write(3, 8'h42);
    push_refresh();
    n = 0;
    while (seen.size() < base + 9 && n < 500) begin @(negedge iCLK); n++; end
    check(n < 500, "third_row1_byte_timeout", n, 500);
    write(0, 8'h5A);
    push_refresh();
    wait_idle("refresh2_timeout");
    check(seen_at(base + 4) == 9'h142, "r2_col3", seen_at(base + 4), 9'h142);
    check(seen_at(base + 11) == 9'h15A, "r3_first_data", seen_at(base + 11), 9'h15A);
    check(seen.size() == base + 20, "two_refreshes", seen.size() - base, 20);

    // out-of-range write is ignored
    r0 = en_rises;
    write(8, 8'h55);
    repeat (40) begin
      @(negedge iCLK);
      check(oBUSY == 0, "busy_oob", oBUSY, 0);
    end
    check(en_rises == r0, "no_en_oob", en_rises - r0, 0);

    // reset while EN is high
    write(1, 8'h43);
    push_refresh();
    n = 0;
    while (!LCD_EN && n < 200) begin @(negedge iCLK); n++; end
    check(LCD_EN == 1, "en_before_reset", LCD_EN, 1);
    #1 iRST = 1'b1;
    @(negedge iCLK);
    check(LCD_EN == 0, "mid_rst_en", LCD_EN, 0);
    check(oINIT_DONE == 0, "mid_rst_init_done", oINIT_DONE, 0);
    check(oBUSY == 1, "mid_rst_busy", oBUSY, 1);
    check(LCD_DATA == 0, "mid_rst_data", LCD_DATA, 0);
    model_clear();
    push_init();
    push_refresh();
    base = seen.size();
    #1 iRST = 1'b0;
    wait_idle("reinit_timeout");
    check(seen_at(base) == 9'h038, "reinit_b0", seen_at(base), 9'h038);
    check(seen_at(base + 5) == 9'h120, "reinit_cleared", seen_at(base + 5), 9'h120);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
